// File: rtl/seg_counter_display.sv
// rtl/seg_counter_display.sv - prescaled up/down counter with sequential BCD conversion and 7-segment decode
// Optional feature macro: SEG_LZ_BLANK_EN (blank leading zero digits above the top nonzero digit)
module seg_counter_display #(
  parameter int DIGITS    = 6,
  parameter int MAX_COUNT = 59,
  parameter int TICK_DIV  = 50000000,
  localparam int CNT_W    = (MAX_COUNT > 0) ? $clog2(MAX_COUNT + 1) : 1
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_N,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  up,
  output logic [CNT_W-1:0]      count,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   HEX,
  output logic                  busy,
  output logic                  wrap
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BC_W  = $clog2(CNT_W + 1);
  localparam int BCD_W = 4 * DIGITS;
  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_COUNT);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(CNT_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } conv_state_t;

  logic [PRE_W-1:0]       presc;
  logic                   tick;
  logic [CNT_W-1:0]       count_nxt;
  logic                   wrap_nxt;
  logic                   change;

  conv_state_t            state_q, state_d;
  logic                   pending_q, pending_d;
  logic [CNT_W-1:0]       bin_sh;
  logic [BCD_W-1:0]       bcd_w;
  logic [BCD_W-1:0]       bcd_adj;
  logic [BCD_W+CNT_W-1:0] dd_shift;
  logic [BC_W-1:0]        bit_cnt;
  logic [DIGITS-1:0]      blank;
`ifdef SEG_LZ_BLANK_EN
  logic                   lz;
`endif

  // Active-low segment pattern for one BCD digit; non-decimal codes are blank
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign tick = en && (presc == PRE_LAST);

  // Prescaler: advances only while enabled, restarts after each tick or on clr
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      presc <= '0;
    end else if (clr) begin
      presc <= '0;
    end else if (en) begin
      presc <= (presc == PRE_LAST) ? '0 : presc + PRE_W'(1);
    end
  end

  // Next count and wrap detection; clr overrides a coincident tick
  always_comb begin
    count_nxt = count;
    wrap_nxt  = 1'b0;
    if (clr) begin
      count_nxt = '0;
    end else if (tick) begin
      if (up) begin
        if (count == MAX_C) begin
          count_nxt = '0;
          wrap_nxt  = 1'b1;
        end else begin
          count_nxt = count + CNT_W'(1);
        end
      end else begin
        if (count == '0) begin
          count_nxt = MAX_C;
          wrap_nxt  = 1'b1;
        end else begin
          count_nxt = count - CNT_W'(1);
        end
      end
    end
  end

  assign change = (count_nxt != count);

  // Count register and one-cycle wrap pulse
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      count <= count_nxt;
      wrap  <= wrap_nxt;
    end
  end

  // Converter state register
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= S_IDLE;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  // Converter sequencing; a count change while busy is remembered and served straight after DONE
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    busy      = 1'b0;
    case (state_q)
      S_IDLE: begin
        pending_d = 1'b0;
        if (change) state_d = S_LOAD;
      end
      S_LOAD: begin
        busy      = 1'b1;
        pending_d = pending_q | change;
        state_d   = S_SHIFT;
      end
      S_SHIFT: begin
        busy      = 1'b1;
        pending_d = pending_q | change;
        if (bit_cnt == BC_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        pending_d = 1'b0;
        state_d   = (pending_q || change) ? S_LOAD : S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        pending_d = 1'b0;
      end
    endcase
  end

  // Add-3 correction of every BCD digit that is 5 or more before the next shift
  always_comb begin
    bcd_adj = bcd_w;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_w[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_w[4*d +: 4] + 4'd3;
    end
  end

  assign dd_shift = {bcd_adj, bin_sh} << 1;

  // Double-dabble datapath: load the count, shift one bit per cycle, publish the result only in DONE
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      bin_sh  <= '0;
      bcd_w   <= '0;
      bit_cnt <= '0;
      bcd     <= '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          bin_sh  <= count;
          bcd_w   <= '0;
          bit_cnt <= '0;
        end
        S_SHIFT: begin
          {bcd_w, bin_sh} <= dd_shift;
          bit_cnt         <= bit_cnt + BC_W'(1);
        end
        S_DONE: begin
          bcd <= bcd_w;
        end
        default: begin
        end
      endcase
    end
  end

  // Segment decode of the published BCD, optionally blanking leading zero digits
  always_comb begin
    blank = '0;
`ifdef SEG_LZ_BLANK_EN
    lz = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      lz       = lz && (bcd[4*k +: 4] == 4'd0);
      blank[k] = lz;
    end
`endif
    HEX = '1;
    for (int k = 0; k < DIGITS; k++) begin
      HEX[7*k +: 7] = blank[k] ? 7'b1111111 : seg7(bcd[4*k +: 4]);
    end
  end

endmodule

// File: tb/tb_seg_counter_display.sv
// tb/tb_seg_counter_display.sv - self-checking bench for seg_counter_display
module tb_seg_counter_display;

  localparam int TD_A  = 4;
  localparam int MAX_A = 59;
  localparam int LAT_A = 8;

  logic clk, rst_n;
  logic en_a, clr_a, up_a;
  logic en_b, clr_b, up_b;
  logic [5:0]  count_a;
  logic [7:0]  bcd_a;
  logic [13:0] HEX_a;
  logic        busy_a, wrap_a;
  logic [19:0] count_b;
  logic [23:0] bcd_b;
  logic [41:0] HEX_b;
  logic        busy_b, wrap_b;

  int total = 0;
  int bad   = 0;

  seg_counter_display #(.DIGITS(2), .MAX_COUNT(MAX_A), .TICK_DIV(TD_A)) dut_a (
    .CLOCK_50(clk), .RESET_N(rst_n), .en(en_a), .clr(clr_a), .up(up_a),
    .count(count_a), .bcd(bcd_a), .HEX(HEX_a), .busy(busy_a), .wrap(wrap_a)
  );

  seg_counter_display #(.DIGITS(6), .MAX_COUNT(999999), .TICK_DIV(1)) dut_b (
    .CLOCK_50(clk), .RESET_N(rst_n), .en(en_b), .clr(clr_b), .up(up_b),
    .count(count_b), .bcd(bcd_b), .HEX(HEX_b), .busy(busy_b), .wrap(wrap_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model for instance A: ticks every TD_A enabled cycles, modular count arithmetic
  int  m_pre, m_cnt;
  logic m_wrap, m_tick;
  bit  seen [0:MAX_A];

  function automatic int step(input int c, input logic u);
    return u ? (c + 1) % (MAX_A + 1) : (c + MAX_A) % (MAX_A + 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pre  <= 0;
      m_cnt  <= 0;
      m_wrap <= 1'b0;
      m_tick <= 1'b0;
      for (int i = 0; i <= MAX_A; i++) seen[i] <= (i == 0);
    end else begin
      m_wrap <= 1'b0;
      m_tick <= 1'b0;
      if (clr_a) begin
        m_pre   <= 0;
        m_cnt   <= 0;
        seen[0] <= 1'b1;
      end else if (en_a) begin
        if (m_pre == TD_A - 1) begin
          m_pre  <= 0;
          m_tick <= 1'b1;
          m_cnt  <= step(m_cnt, up_a);
          m_wrap <= up_a ? (m_cnt == MAX_A) : (m_cnt == 0);
          seen[step(m_cnt, up_a)] <= 1'b1;
        end else begin
          m_pre <= m_pre + 1;
        end
      end
    end
  end

  function automatic logic [6:0] seg_pat(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [41:0] hex_of(input int v, input int nd);
    logic [41:0] h;
    logic [6:0]  s;
    int p;
    h = '0;
    p = 1;
    for (int k = 0; k < nd; k++) begin
      s = seg_pat((v / p) % 10);
`ifdef SEG_LZ_BLANK_EN
      if (k > 0 && v < p) s = 7'b1111111;
`endif
      h[7*k +: 7] = s;
      p = p * 10;
    end
    return h;
  endfunction

  function automatic logic [23:0] bcd_of(input int v, input int nd);
    logic [23:0] h;
    int p;
    h = '0;
    p = 1;
    for (int k = 0; k < nd; k++) begin
      h[4*k +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return h;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle of instance A with per-cycle checks against the model
  task automatic cyc_a();
    int hi, lo;
    logic ok;
    @(negedge clk);
    chk("count_a", 64'(count_a), 64'(m_cnt));
    chk("wrap_a", 64'(wrap_a), 64'(m_wrap));
    hi = int'(bcd_a[7:4]);
    lo = int'(bcd_a[3:0]);
    ok = 1'b0;
    if (hi <= 9 && lo <= 9 && (hi * 10 + lo) <= MAX_A) ok = seen[hi * 10 + lo];
    chk("bcd_a_valid", 64'(ok), 64'(1'b1));
    if (ok) chk("hex_a_decode", 64'(HEX_a), 64'(hex_of(hi * 10 + lo, 2)));
  endtask

  task automatic wait_idle_a();
    int lows, n;
    lows = 0;
    n = 0;
    while (lows < 2 && n < 60) begin
      cyc_a();
      lows = busy_a ? 0 : lows + 1;
      n++;
    end
    chk("idle_a", 64'(busy_a), 64'(1'b0));
  endtask

  task automatic wait_idle_b();
    int lows, n;
    lows = 0;
    n = 0;
    while (lows < 2 && n < 46) begin
      @(negedge clk);
      lows = busy_b ? 0 : lows + 1;
      n++;
    end
    chk("idle_b", 64'(busy_b), 64'(1'b0));
  endtask

  // Single tick from idle converter, then exact-latency check of the bcd update
  task automatic one_tick_a(input logic u, input logic [7:0] old_bcd,
                            input logic [7:0] new_bcd, input logic exp_wrap);
    int n;
    up_a = u;
    en_a = 1'b1;
    n = 0;
    do begin
      cyc_a();
      n++;
    end while (!m_tick && n < TD_A + 2);
    en_a = 1'b0;
    chk("tick_seen", 64'(m_tick), 64'(1'b1));
    chk("wrap_pulse", 64'(wrap_a), 64'(exp_wrap));
    for (int k = 1; k < LAT_A; k++) begin
      cyc_a();
      if (k == 1) chk("busy_conv", 64'(busy_a), 64'(1'b1));
      chk("bcd_hold", 64'(bcd_a), 64'(old_bcd));
    end
    cyc_a();
    chk("bcd_latency", 64'(bcd_a), 64'(new_bcd));
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    en_a = 1'b0; clr_a = 1'b0; up_a = 1'b1;
    en_b = 1'b0; clr_b = 1'b0; up_b = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_count_a", 64'(count_a), 64'(0));
    chk("rst_bcd_a", 64'(bcd_a), 64'(0));
    chk("rst_busy_a", 64'(busy_a), 64'(0));
    chk("rst_wrap_a", 64'(wrap_a), 64'(0));
    chk("rst_hex_a", 64'(HEX_a), 64'(hex_of(0, 2)));
    chk("rst_hex_b", 64'(HEX_b), 64'(hex_of(0, 6)));
    rst_n = 1'b1;

    // Instance B: one tick per enabled cycle, pending mechanism keeps up
    @(negedge clk);
    en_b = 1'b1;
    repeat (20) @(negedge clk);
    en_b = 1'b0;
    chk("b_count20", 64'(count_b), 64'(20));
    wait_idle_b();
    chk("b_bcd20", 64'(bcd_b), 64'(bcd_of(20, 6)));
    chk("b_hex20", 64'(HEX_b), 64'(hex_of(20, 6)));
    chk("b_hold20", 64'(count_b), 64'(20));
    clr_b = 1'b1;
    @(negedge clk);
    clr_b = 1'b0;
    chk("b_clr", 64'(count_b), 64'(0));
    en_b = 1'b1;
    repeat (7) @(negedge clk);
    en_b = 1'b0;
    wait_idle_b();
    chk("b_count7", 64'(count_b), 64'(7));
    chk("b_bcd7", 64'(bcd_b), 64'(bcd_of(7, 6)));
    chk("b_hex7", 64'(HEX_b), 64'(hex_of(7, 6)));

    // Instance A: count up to MAX
    en_a = 1'b1; up_a = 1'b1;
    n = 0;
    while (m_cnt != MAX_A && n < 300) begin
      cyc_a();
      n++;
    end
    en_a = 1'b0;
    wait_idle_a();
    chk("a_count59", 64'(count_a), 64'(59));
    chk("a_bcd59", 64'(bcd_a), 64'(8'h59));
    chk("a_hex59", 64'(HEX_a), 64'({7'b0010010, 7'b0010000}));

    // Up wrap then down wrap, each from an idle converter
    one_tick_a(1'b1, 8'h59, 8'h00, 1'b1);
    chk("a_wrap_count0", 64'(count_a), 64'(0));
    chk("a_hex0", 64'(HEX_a), 64'(hex_of(0, 2)));
    one_tick_a(1'b0, 8'h00, 8'h59, 1'b1);
    chk("a_down_count59", 64'(count_a), 64'(59));
    one_tick_a(1'b0, 8'h59, 8'h58, 1'b0);

    // Randomized bursts of enable, direction and clear
    for (int it = 0; it < 25; it++) begin
      up_a = 1'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        clr_a = 1'b1;
        cyc_a();
        clr_a = 1'b0;
      end
      en_a = 1'b1;
      repeat ($urandom_range(1, 14)) cyc_a();
      en_a = 1'b0;
      if ($urandom_range(0, 2) == 0) begin
        wait_idle_a();
        chk("a_bcd_rand", 64'(bcd_a), 64'(bcd_of(m_cnt, 2)));
      end
    end

    // clr coincident with a tick at count 37
    wait_idle_a();
    clr_a = 1'b1;
    cyc_a();
    clr_a = 1'b0;
    en_a = 1'b1; up_a = 1'b1;
    n = 0;
    while (m_cnt != 37 && n < 200) begin
      cyc_a();
      n++;
    end
    chk("a_reach37", 64'(count_a), 64'(37));
    repeat (3) cyc_a();
    clr_a = 1'b1;
    cyc_a();
    clr_a = 1'b0;
    en_a = 1'b0;
    chk("a_clr_count", 64'(count_a), 64'(0));
    chk("a_clr_nowrap", 64'(wrap_a), 64'(0));
    cyc_a();
    chk("a_clr_nowrap2", 64'(wrap_a), 64'(0));
    wait_idle_a();
    chk("a_clr_bcd", 64'(bcd_a), 64'(8'h00));
    en_a = 1'b1;
    repeat (3) cyc_a();
    chk("a_presc_cleared", 64'(count_a), 64'(0));
    cyc_a();
    chk("a_presc_tick", 64'(count_a), 64'(1));
    en_a = 1'b0;

    // Reset in the middle of converting 45
    wait_idle_a();
    en_a = 1'b1;
    n = 0;
    while (m_cnt != 44 && n < 250) begin
      cyc_a();
      n++;
    end
    en_a = 1'b0;
    wait_idle_a();
    chk("a_bcd44", 64'(bcd_a), 64'(8'h44));
    en_a = 1'b1;
    n = 0;
    do begin
      cyc_a();
      n++;
    end while (!m_tick && n < TD_A + 2);
    en_a = 1'b0;
    cyc_a();
    cyc_a();
    chk("a_busy_before_rst", 64'(busy_a), 64'(1'b1));
    rst_n = 1'b0;
    #1;
    chk("rst2_count_a", 64'(count_a), 64'(0));
    chk("rst2_bcd_a", 64'(bcd_a), 64'(0));
    chk("rst2_busy_a", 64'(busy_a), 64'(0));
    chk("rst2_wrap_a", 64'(wrap_a), 64'(0));
    chk("rst2_hex_a", 64'(HEX_a), 64'(hex_of(0, 2)));
    chk("rst2_count_b", 64'(count_b), 64'(0));
    chk("rst2_bcd_b", 64'(bcd_b), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2 * LAT_A; k++) begin
      cyc_a();
      chk("post_rst_bcd", 64'(bcd_a), 64'(0));
      chk("post_rst_busy", 64'(busy_a), 64'(0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
